// File: rtl/rst_seq_ctrl_if.sv
// Reset sequencer request/status bundle: reset requests and cause clear in,
// sequenced reset outputs and status out.
interface rst_seq_ctrl_if #(
  parameter int unsigned NUM_CH = 4
);
  logic              SYSRESETREQ;
  logic              LOCKUPRESET;
  logic              WDOGRESREQ;
  logic [NUM_CH-1:0] SWRST_REQ;
  logic              CAUSE_CLR;
  logic              PORESETn;
  logic              HRESETn;
  logic [NUM_CH-1:0] CH_RESETn;
  logic              RST_BUSY;
  logic [3:0]        RST_CAUSE;

  modport master (
    output SYSRESETREQ, LOCKUPRESET, WDOGRESREQ, SWRST_REQ, CAUSE_CLR,
    input  PORESETn, HRESETn, CH_RESETn, RST_BUSY, RST_CAUSE
  );

  modport slave (
    input  SYSRESETREQ, LOCKUPRESET, WDOGRESREQ, SWRST_REQ, CAUSE_CLR,
    output PORESETn, HRESETn, CH_RESETn, RST_BUSY, RST_CAUSE
  );
endinterface

// File: rtl/rst_seq_ctrl.sv
// Reset sequencer: stretches power-on reset, holds system reset for a minimum time,
// releases peripheral channels in staggered order, supports per-channel soft reset.
module rst_seq_ctrl #(
  parameter int unsigned NUM_CH     = 4,
  parameter int unsigned CNT_W      = 8,
  parameter int unsigned POR_CYCLES = 8,
  parameter int unsigned MIN_ASSERT = 16,
  parameter int unsigned STAGGER    = 4,
  parameter bit          LOCKUP_EN  = 1'b1
) (
  input  logic          CLKIN,
  input  logic          RSTIN,
  rst_seq_ctrl_if.slave bus
);

  localparam int unsigned      IDX_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  // The first RSTIN-low edge is cycle 0, so the POR count runs to the full value.
  localparam logic [CNT_W-1:0] POR_TERM  = CNT_W'(POR_CYCLES);
  localparam logic [CNT_W-1:0] HOLD_TERM = CNT_W'(MIN_ASSERT - 1);
  localparam logic [CNT_W-1:0] STG_TERM  = CNT_W'(STAGGER - 1);
  localparam logic [IDX_W-1:0] LAST_CH   = IDX_W'(NUM_CH - 1);

  typedef enum logic [1:0] {
    S_POR_HOLD,
    S_SYS_HOLD,
    S_STAGGER,
    S_RUN
  } state_t;

  state_t                       state, nxt_state;
  logic [CNT_W-1:0]             cnt, nxt_cnt;
  logic [IDX_W-1:0]             idx, nxt_idx;
  logic                         por_n, nxt_por_n;
  logic                         hrst_n, nxt_hrst_n;
  logic [NUM_CH-1:0]            ch_n, nxt_ch_n;
  logic [NUM_CH-1:0]            sw_act, nxt_sw_act;
  logic [NUM_CH-1:0][CNT_W-1:0] sw_cnt, nxt_sw_cnt;
  logic                         busy, nxt_busy;
  logic [3:0]                   cause, nxt_cause;
  logic                         lock_req;
  logic                         sys_req;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  always_comb begin
    lock_req   = bus.LOCKUPRESET & LOCKUP_EN;
    sys_req    = bus.SYSRESETREQ | bus.WDOGRESREQ | lock_req;
    nxt_state  = state;
    nxt_cnt    = cnt;
    nxt_idx    = idx;
    nxt_por_n  = por_n;
    nxt_hrst_n = hrst_n;
    nxt_ch_n   = ch_n;
    nxt_sw_act = sw_act;
    nxt_sw_cnt = sw_cnt;
    // Set beats clear per bit; the clear only drops bits not being set this cycle.
    nxt_cause  = (cause & ~{4{bus.CAUSE_CLR}})
               | {bus.WDOGRESREQ, lock_req, bus.SYSRESETREQ, 1'b0};

    if (sys_req && (state != S_POR_HOLD)) begin
      nxt_state  = S_SYS_HOLD;
      nxt_cnt    = '0;
      nxt_idx    = '0;
      nxt_hrst_n = 1'b0;
      nxt_ch_n   = '0;
      nxt_sw_act = '0;
      nxt_sw_cnt = '0;
    end else begin
      case (state)
        S_POR_HOLD: begin
          if (cnt == POR_TERM) begin
            nxt_por_n = 1'b1;
            nxt_state = S_SYS_HOLD;
            nxt_cnt   = '0;
          end else begin
            nxt_cnt = sat_inc(cnt);
          end
        end
        S_SYS_HOLD: begin
          if (cnt == HOLD_TERM) begin
            nxt_hrst_n = 1'b1;
            nxt_state  = S_STAGGER;
            nxt_cnt    = '0;
            nxt_idx    = '0;
          end else begin
            nxt_cnt = sat_inc(cnt);
          end
        end
        S_STAGGER: begin
          if (cnt == STG_TERM) begin
            nxt_ch_n[idx] = 1'b1;
            nxt_cnt       = '0;
            if (idx == LAST_CH) begin
              nxt_state = S_RUN;
            end else begin
              nxt_idx = idx + 1'b1;
            end
          end else begin
            nxt_cnt = sat_inc(cnt);
          end
        end
        S_RUN: begin
          for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (bus.SWRST_REQ[i]) begin
              nxt_sw_act[i] = 1'b1;
              nxt_sw_cnt[i] = '0;
              nxt_ch_n[i]   = 1'b0;
            end else if (sw_act[i]) begin
              if (sw_cnt[i] == HOLD_TERM) begin
                nxt_sw_act[i] = 1'b0;
                nxt_sw_cnt[i] = '0;
                nxt_ch_n[i]   = 1'b1;
              end else begin
                nxt_sw_cnt[i] = sat_inc(sw_cnt[i]);
              end
            end
          end
        end
        default: nxt_state = S_POR_HOLD;
      endcase
    end

    nxt_busy = (nxt_state != S_RUN) || (|nxt_sw_act);
  end

  always_ff @(posedge CLKIN) begin
    if (RSTIN) begin
      state  <= S_POR_HOLD;
      cnt    <= '0;
      idx    <= '0;
      por_n  <= 1'b0;
      hrst_n <= 1'b0;
      ch_n   <= '0;
      sw_act <= '0;
      sw_cnt <= '0;
      busy   <= 1'b1;
      cause  <= 4'b0001;
    end else begin
      state  <= nxt_state;
      cnt    <= nxt_cnt;
      idx    <= nxt_idx;
      por_n  <= nxt_por_n;
      hrst_n <= nxt_hrst_n;
      ch_n   <= nxt_ch_n;
      sw_act <= nxt_sw_act;
      sw_cnt <= nxt_sw_cnt;
      busy   <= nxt_busy;
      cause  <= nxt_cause;
    end
  end

  assign bus.PORESETn  = por_n;
  assign bus.HRESETn   = hrst_n;
  assign bus.CH_RESETn = ch_n;
  assign bus.RST_BUSY  = busy;
  assign bus.RST_CAUSE = cause;

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// Bench for rst_seq_ctrl: vector table, hand-written corner sequences and
// randomized traffic against an event-time reference model.
module tb_rst_seq_ctrl;
  localparam int NCH = 4;
  localparam int POR = 8;
  localparam int MIN = 16;
  localparam int STG = 4;

  logic           clk = 1'b0;
  logic           rstin = 1'b1;
  logic           sysreq = 1'b0, lockup = 1'b0, wdog = 1'b0, cclr = 1'b0;
  logic [NCH-1:0] swrst = '0;

  int n_pass = 0;
  int n_tot  = 0;

  always #5 clk = ~clk;

  rst_seq_ctrl_if #(.NUM_CH(NCH)) ifm ();
  rst_seq_ctrl_if #(.NUM_CH(NCH)) ifn ();

  assign ifm.SYSRESETREQ = sysreq;
  assign ifm.LOCKUPRESET = lockup;
  assign ifm.WDOGRESREQ  = wdog;
  assign ifm.SWRST_REQ   = swrst;
  assign ifm.CAUSE_CLR   = cclr;
  assign ifn.SYSRESETREQ = sysreq;
  assign ifn.LOCKUPRESET = lockup;
  assign ifn.WDOGRESREQ  = wdog;
  assign ifn.SWRST_REQ   = swrst;
  assign ifn.CAUSE_CLR   = cclr;

  rst_seq_ctrl #(.NUM_CH(NCH), .CNT_W(8), .POR_CYCLES(POR), .MIN_ASSERT(MIN),
                 .STAGGER(STG), .LOCKUP_EN(1'b1))
    u_dut (.CLKIN(clk), .RSTIN(rstin), .bus(ifm.slave));

  rst_seq_ctrl #(.NUM_CH(NCH), .CNT_W(8), .POR_CYCLES(POR), .MIN_ASSERT(MIN),
                 .STAGGER(STG), .LOCKUP_EN(1'b0))
    u_dut_nl (.CLKIN(clk), .RSTIN(rstin), .bus(ifn.slave));

  // Reference model: absolute edge numbers at which each output rises.
  int         edge_no = 0;
  int         last_e  = 0;
  int         por_rise = 1 << 20;
  int         h_rise   = 1 << 20;
  int         sw_rise [NCH];
  logic [3:0] m_cause = 4'b0001;

  function automatic void model_edge(input int e);
    logic r;
    r = sysreq | wdog | lockup;
    if (rstin) begin
      por_rise = e + 1 + POR;
      h_rise   = por_rise + MIN;
      for (int i = 0; i < NCH; i++) sw_rise[i] = 0;
      m_cause  = 4'b0001;
    end else begin
      if (r && e > por_rise) begin
        h_rise = e + MIN;
        for (int i = 0; i < NCH; i++) sw_rise[i] = 0;
      end else if (e > h_rise + NCH * STG) begin
        for (int i = 0; i < NCH; i++) if (swrst[i]) sw_rise[i] = e + MIN;
      end
      m_cause = (cclr ? 4'b0000 : m_cause) | {wdog, lockup, sysreq, 1'b0};
    end
  endfunction

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      model_edge(edge_no);
      last_e = edge_no;
      edge_no++;
    end
  endtask

  task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] exp);
    n_tot++;
    if (act !== exp)
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    else
      n_pass++;
  endtask

  task automatic chk_model(input string tag);
    logic [3:0] ech;
    logic       eb;
    eb = (last_e < h_rise + NCH * STG);
    for (int i = 0; i < NCH; i++) begin
      ech[i] = (last_e >= h_rise + (i + 1) * STG) && (last_e >= sw_rise[i]);
      if (last_e < sw_rise[i]) eb = 1'b1;
    end
    chk({tag, ".por"},   4'(ifm.PORESETn), 4'(last_e >= por_rise));
    chk({tag, ".h"},     4'(ifm.HRESETn),  4'(last_e >= h_rise));
    chk({tag, ".ch"},    ifm.CH_RESETn,    ech);
    chk({tag, ".busy"},  4'(ifm.RST_BUSY), 4'(eb));
    chk({tag, ".cause"}, ifm.RST_CAUSE,    m_cause);
  endtask

  typedef struct {
    logic       rst, sys, lk, wd, clr;
    logic [3:0] sw;
    int         cyc;
    logic       por, h;
    logic [3:0] ch;
    logic       busy;
    logic [3:0] cause;
  } vec_t;

  vec_t vt [22];

  initial begin
    // rst sys lk wd clr sw cyc | por h ch busy cause
    vt[0]  = '{1'b1,1'b0,1'b0,1'b0,1'b0,4'h0, 5, 1'b0,1'b0,4'h0,1'b1,4'h1};
    vt[1]  = '{1'b0,1'b0,1'b0,1'b0,1'b0,4'h0, 8, 1'b0,1'b0,4'h0,1'b1,4'h1};
    vt[2]  = '{1'b0,1'b0,1'b0,1'b0,1'b0,4'h0, 1, 1'b1,1'b0,4'h0,1'b1,4'h1};
    vt[3]  = '{1'b0,1'b0,1'b0,1'b0,1'b0,4'h0,15, 1'b1,1'b0,4'h0,1'b1,4'h1};
    vt[4]  = '{1'b0,1'b0,1'b0,1'b0,1'b0,4'h0, 1, 1'b1,1'b1,4'h0,1'b1,4'h1};
    vt[5]  = '{1'b0,1'b0,1'b0,1'b0,1'b0,4'h0, 3, 1'b1,1'b1,4'h0,1'b1,4'h1};
    vt[6]  = '{1'b0,1'b0,1'b0,1'b0,1'b0,4'h0, 1, 1'b1,1'b1,4'h1,1'b1,4'h1};
    vt[7]  = '{1'b0,1'b0,1'b0,1'b0,1'b0,4'h0, 4, 1'b1,1'b1,4'h3,1'b1,4'h1};
    vt[8]  = '{1'b0,1'b0,1'b0,1'b0,1'b0,4'h0, 4, 1'b1,1'b1,4'h7,1'b1,4'h1};
    vt[9]  = '{1'b0,1'b0,1'b0,1'b0,1'b0,4'h0, 3, 1'b1,1'b1,4'h7,1'b1,4'h1};
    vt[10] = '{1'b0,1'b0,1'b0,1'b0,1'b0,4'h0, 1, 1'b1,1'b1,4'hF,1'b0,4'h1};
    vt[11] = '{1'b0,1'b0,1'b0,1'b0,1'b0,4'h0, 3, 1'b1,1'b1,4'hF,1'b0,4'h1};
    vt[12] = '{1'b0,1'b1,1'b0,1'b0,1'b0,4'h0, 1, 1'b1,1'b0,4'h0,1'b1,4'h3};
    vt[13] = '{1'b0,1'b0,1'b0,1'b0,1'b0,4'h0,15, 1'b1,1'b0,4'h0,1'b1,4'h3};
    vt[14] = '{1'b0,1'b0,1'b0,1'b0,1'b0,4'h0, 1, 1'b1,1'b1,4'h0,1'b1,4'h3};
    vt[15] = '{1'b0,1'b0,1'b0,1'b0,1'b0,4'h0, 4, 1'b1,1'b1,4'h1,1'b1,4'h3};
    vt[16] = '{1'b0,1'b0,1'b0,1'b0,1'b0,4'h0,11, 1'b1,1'b1,4'h7,1'b1,4'h3};
    vt[17] = '{1'b0,1'b0,1'b0,1'b0,1'b0,4'h0, 1, 1'b1,1'b1,4'hF,1'b0,4'h3};
    vt[18] = '{1'b0,1'b0,1'b0,1'b1,1'b1,4'h0, 1, 1'b1,1'b0,4'h0,1'b1,4'h8};
    vt[19] = '{1'b0,1'b0,1'b0,1'b0,1'b0,4'h0,15, 1'b1,1'b0,4'h0,1'b1,4'h8};
    vt[20] = '{1'b0,1'b0,1'b0,1'b0,1'b0,4'h0, 1, 1'b1,1'b1,4'h0,1'b1,4'h8};
    vt[21] = '{1'b0,1'b0,1'b0,1'b0,1'b0,4'h0,16, 1'b1,1'b1,4'hF,1'b0,4'h8};

    for (int k = 0; k < 22; k++) begin
      rstin = vt[k].rst; sysreq = vt[k].sys; lockup = vt[k].lk;
      wdog = vt[k].wd; cclr = vt[k].clr; swrst = vt[k].sw;
      step(vt[k].cyc);
      chk($sformatf("v%0d.por", k),   4'(ifm.PORESETn), 4'(vt[k].por));
      chk($sformatf("v%0d.h", k),     4'(ifm.HRESETn),  4'(vt[k].h));
      chk($sformatf("v%0d.ch", k),    ifm.CH_RESETn,    vt[k].ch);
      chk($sformatf("v%0d.busy", k),  4'(ifm.RST_BUSY), 4'(vt[k].busy));
      chk($sformatf("v%0d.cause", k), ifm.RST_CAUSE,    vt[k].cause);
    end
    rstin = 1'b0; sysreq = 1'b0; lockup = 1'b0; wdog = 1'b0; cclr = 1'b0; swrst = '0;

    // Watchdog held for 10 cycles: release MIN_ASSERT cycles after it drops.
    wdog = 1'b1; step(10);
    chk("wdog_held.h", 4'(ifm.HRESETn), 4'h0);
    wdog = 1'b0; step(15);
    chk("wdog_tail.h", 4'(ifm.HRESETn), 4'h0);
    step(1);
    chk("wdog_rel.h", 4'(ifm.HRESETn), 4'h1);
    step(16);
    chk("wdog_run.ch", ifm.CH_RESETn, 4'hF);
    chk("wdog_run.busy", 4'(ifm.RST_BUSY), 4'h0);

    // Lockup honoured when enabled, ignored entirely when disabled.
    lockup = 1'b1; step(1); lockup = 1'b0;
    chk("lk_en.h", 4'(ifm.HRESETn), 4'h0);
    chk("lk_en.por", 4'(ifm.PORESETn), 4'h1);
    chk("lk_en.cause", ifm.RST_CAUSE, 4'hC);
    chk("lk_dis.h", 4'(ifn.HRESETn), 4'h1);
    chk("lk_dis.busy", 4'(ifn.RST_BUSY), 4'h0);
    chk("lk_dis.cause", ifn.RST_CAUSE, 4'h8);
    step(32);
    chk("lk_run.ch", ifm.CH_RESETn, 4'hF);
    chk("lk_run.busy", 4'(ifm.RST_BUSY), 4'h0);

    // Soft reset of channel 2 with a restart pulse 8 cycles in.
    swrst = 4'b0100; step(1); swrst = '0;
    chk("sw_start.ch", ifm.CH_RESETn, 4'b1011);
    chk("sw_start.busy", 4'(ifm.RST_BUSY), 4'h1);
    step(7);
    chk("sw_mid.ch", ifm.CH_RESETn, 4'b1011);
    swrst = 4'b0100; step(1); swrst = '0;
    step(15);
    chk("sw_ext.ch", ifm.CH_RESETn, 4'b1011);
    chk("sw_ext.busy", 4'(ifm.RST_BUSY), 4'h1);
    step(1);
    chk("sw_rel.ch", ifm.CH_RESETn, 4'hF);
    chk("sw_rel.busy", 4'(ifm.RST_BUSY), 4'h0);

    // RSTIN mid-stagger restarts the whole sequence.
    sysreq = 1'b1; step(1); sysreq = 1'b0;
    step(20);
    chk("stg.ch", ifm.CH_RESETn, 4'h1);
    rstin = 1'b1; step(1); rstin = 1'b0;
    chk("rst_mid.por", 4'(ifm.PORESETn), 4'h0);
    chk("rst_mid.h", 4'(ifm.HRESETn), 4'h0);
    chk("rst_mid.ch", ifm.CH_RESETn, 4'h0);
    chk("rst_mid.busy", 4'(ifm.RST_BUSY), 4'h1);
    chk("rst_mid.cause", ifm.RST_CAUSE, 4'h1);
    step(8);
    chk("re_por_lo", 4'(ifm.PORESETn), 4'h0);
    step(1);
    chk("re_por_hi", 4'(ifm.PORESETn), 4'h1);
    step(16);
    chk("re_h_hi", 4'(ifm.HRESETn), 4'h1);
    step(16);
    chk("re_run.ch", ifm.CH_RESETn, 4'hF);
    chk("re_run.busy", 4'(ifm.RST_BUSY), 4'h0);

    // Randomized traffic against the reference model.
    for (int c = 0; c < 1500; c++) begin
      rstin  = ($urandom_range(0, 299) == 0);
      sysreq = ($urandom_range(0, 59) == 0);
      wdog   = ($urandom_range(0, 89) == 0);
      lockup = ($urandom_range(0, 119) == 0);
      cclr   = ($urandom_range(0, 15) == 0);
      for (int i = 0; i < NCH; i++) swrst[i] = ($urandom_range(0, 24) == 0);
      step(1);
      chk_model($sformatf("rnd%0d", c));
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
